fpu_md_mantissa_core: RTL and testbench
=======================================

Name: fpu_md_mantissa_core

Overview:
- Iterative multiply/divide datapath for the single-precision FPU.
- Unpacks two IEEE-754 operands and computes the sign and the biased pre-normalization exponent.
- Runs a radix-2 shift-add multiply or a restoring divide on the 24-bit mantissas.
- Presents registered results directly to the post-normalization stage: exp, mul_result, div_result, redundant_mul, div_mul, sign.

Parameters:
- MANT_W, 24, mantissa width including hidden bit.
- EXP_W, 8, exponent width.
- BIAS, 127, exponent bias.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while ready=1.
- op_div  input  1  0 = multiply, 1 = divide (captured at start).
- op_a  input  32  operand A / dividend.
- op_b  input  32  operand B / divisor.
- ready  output  1  high in IDLE only.
- out_valid  output  1  one-cycle pulse when results are valid.
- sign  output  1  sign_a XOR sign_b.
- exp  output  EXP_W  biased pre-normalization exponent.
- mul_result  output  MANT_W  product bits [46:23].
- div_result  output  MANT_W  quotient, bit 23 has weight 2^0.
- redundant_mul  output  1  product bit 47.
- div_mul  output  1  registered op_div.
- zero_flag  output  1  an operand was zero (exp field 0).
- dbz_flag  output  1  divide with op_b zero.
- exp_ovf  output  1  exponent above 254 before normalization.
- exp_unf  output  1  exponent below 1 before normalization.

Behaviour:
- Clock and reset: one clock domain (clk). rst is asynchronous and active-high.
- Reset:
  - FSM goes to IDLE and counter = 0.
  - All outputs are 0 except ready = 1.
  - Reset asserted mid-operation discards the operation; no out_valid is produced.
- FSM states: IDLE, CALC, DONE.
  - IDLE: ready = 1. start = 1 captures the operands, op_div, sign and exponents.
    - If zero_flag or dbz_flag applies, go to DONE.
    - Otherwise go to CALC with counter = 0.
  - CALC: one quotient bit or one multiplier bit per cycle, 24 cycles (counter 0..23). Go to DONE when counter = 23.
  - DONE: register all outputs, pulse out_valid for one cycle, return to IDLE.
- Latency:
  - Start accepted at edge k gives out_valid during the cycle after edge k+25.
  - Special-case shortcut: out_valid during the cycle after edge k+1.
- Throughput: one operation per 26 cycles. start while ready = 0 is ignored and not queued.
- Output hold: outputs other than out_valid hold their value until the next DONE or reset.
- Unpacking: mantissa = {exp_field != 0, frac}. Denormals are treated as zero.
- Multiply:
  - 48-bit accumulator, LSB-first shift-add over 24 cycles.
  - redundant_mul = P[47]; mul_result = P[46:23], truncated with no rounding.
  - exp = e_a + e_b - BIAS, computed in a 10-bit signed intermediate.
- Divide:
  - Restoring division of m_a by m_b, 26-bit partial remainder, one bit per cycle MSB-first.
  - div_result[23-i] is the quotient bit of weight 2^-i. Since m_a, m_b are in [1,2), div_result[23] or div_result[22] is always 1.
  - exp = e_a - e_b + BIAS in the 10-bit intermediate.
- Exponent range:
  - Intermediate > 254: exp_ovf = 1, exp = 0xFF.
  - Intermediate < 1: exp_unf = 1, exp = 0x00.
  - Otherwise: exp = intermediate[7:0].
- Special cases (mantissa outputs 0, redundant_mul = 0):
  - Any zero operand (multiply), or zero dividend with nonzero divisor: zero_flag = 1, exp = 0.
  - op_div = 1 and op_b zero: dbz_flag = 1, exp = 0xFF, zero_flag = 0. dbz takes priority when both operands are zero.
- Inf/NaN: not detected here; handled by the FPU exception block.
- Only one of zero_flag, dbz_flag, exp_ovf, exp_unf is set per result.

Test Plan:
- Multiply 0x3FC00000 x 0x3FC00000 -> after 26 cycles: out_valid, redundant_mul=1, mul_result=0x200000, exp=0x7F, sign=0, div_mul=0.
- Divide 0x40400000 / 0x40000000 -> div_result=0xC00000, exp=0x7F, div_mul=1. Divide 0x3F800000 / 0x3FC00000 -> div_result=0x555555, exp=0x7F.
- Multiply 0x00000000 x 0xC0000000 -> out_valid two cycles after start, zero_flag=1, sign=1, mul_result=0. Divide 0x3F800000 / 0x00000000 -> dbz_flag=1, exp=0xFF.
- Multiply 0x7F000000 x 0x7F000000 -> exp_ovf=1, exp=0xFF. Multiply 0x00800000 x 0x00800000 -> exp_unf=1, exp=0x00.
- start pulsed during CALC with different operands -> ignored; the original result is delivered and ready rises afterwards.
- rst asserted at CALC cycle 10 -> immediately ready=1 and outputs 0; no out_valid. A new start after reset completes normally.

Source files
------------

// File: rtl/fpu_md_mantissa_core.sv
// fpu_md_mantissa_core: iterative shift-add multiply / restoring divide on the 24-bit mantissas of two single-precision operands.
// Ports: clk, rst (async, high); start/op_div/op_a/op_b request; ready in IDLE;
// out_valid pulse with sign, exp, mul_result, div_result, redundant_mul, div_mul, zero_flag, dbz_flag, exp_ovf, exp_unf.
module fpu_md_mantissa_core #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8,
  parameter int BIAS   = 127
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op_div,
  input  logic [31:0]       op_a,
  input  logic [31:0]       op_b,
  output logic              ready,
  output logic              out_valid,
  output logic              sign,
  output logic [EXP_W-1:0]  exp,
  output logic [MANT_W-1:0] mul_result,
  output logic [MANT_W-1:0] div_result,
  output logic              redundant_mul,
  output logic              div_mul,
  output logic              zero_flag,
  output logic              dbz_flag,
  output logic              exp_ovf,
  output logic              exp_unf
);
  localparam int PW = 2 * MANT_W;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(MANT_W) + 1;
  localparam logic signed [EW-1:0] EMAX  = EW'(2 ** EXP_W - 2);
  localparam logic signed [EW-1:0] EMIN  = EW'(1);
  localparam logic signed [EW-1:0] EBIAS = EW'(BIAS);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [EXP_W-1:0] ea, eb;
  logic [MANT_W-1:0] ma_c, mb_c, ma, mb, q;
  logic [PW-1:0] acc;
  logic [MANT_W+1:0] rem, rem_sub;
  logic [MANT_W:0] sum;
  logic signed [EW-1:0] ei_c, ei;
  logic ge, zf_c, dbz_c, zf, dbz, div_r, sgn_r, special;
  assign ea = op_a[MANT_W-1 +: EXP_W];
  assign eb = op_b[MANT_W-1 +: EXP_W];
  // denormals collapse to zero: hidden bit only set for a nonzero exponent field
  assign ma_c = {|ea, op_a[MANT_W-2:0]};
  assign mb_c = {|eb, op_b[MANT_W-2:0]};
  assign dbz_c = op_div && eb == '0;
  assign zf_c = !dbz_c && (ea == '0 || (!op_div && eb == '0));
  assign ei_c = op_div ? EW'(ea) - EW'(eb) + EBIAS : EW'(ea) + EW'(eb) - EBIAS;
  // multiplier sits in the low half of acc and is shifted out LSB-first as partial sums enter the top
  assign sum = {1'b0, acc[PW-1:MANT_W]} + (acc[0] ? {1'b0, ma} : '0);
  assign ge = rem >= {2'b00, mb};
  assign rem_sub = ge ? rem - {2'b00, mb} : rem;
  assign special = zf || dbz;
  assign ready = state == IDLE;
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (start ? (zf_c || dbz_c ? DONE : CALC) : IDLE)
              : state == CALC ? (cnt == CW'(MANT_W - 1) ? DONE : CALC)
              : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ma <= '0;
      mb <= '0;
      acc <= '0;
      rem <= '0;
      q <= '0;
      ei <= '0;
      zf <= 1'b0;
      dbz <= 1'b0;
      div_r <= 1'b0;
      sgn_r <= 1'b0;
      out_valid <= 1'b0;
      sign <= 1'b0;
      exp <= '0;
      mul_result <= '0;
      div_result <= '0;
      redundant_mul <= 1'b0;
      div_mul <= 1'b0;
      zero_flag <= 1'b0;
      dbz_flag <= 1'b0;
      exp_ovf <= 1'b0;
      exp_unf <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (state == IDLE && start) begin
        cnt <= '0;
        ma <= ma_c;
        mb <= mb_c;
        acc <= {{MANT_W{1'b0}}, mb_c};
        rem <= {2'b00, ma_c};
        q <= '0;
        ei <= ei_c;
        zf <= zf_c;
        dbz <= dbz_c;
        div_r <= op_div;
        sgn_r <= op_a[31] ^ op_b[31];
      end
      if (state == CALC) begin
        cnt <= cnt + 1'b1;
        acc <= {sum, acc[MANT_W-1:1]};
        rem <= {rem_sub[MANT_W:0], 1'b0};
        q <= {q[MANT_W-2:0], ge};
      end
      if (state == DONE) begin
        out_valid <= 1'b1;
        sign <= sgn_r;
        div_mul <= div_r;
        zero_flag <= zf;
        dbz_flag <= dbz;
        exp <= dbz ? '1 : zf ? '0 : ei > EMAX ? '1 : ei < EMIN ? '0 : ei[EXP_W-1:0];
        exp_ovf <= !special && ei > EMAX;
        exp_unf <= !special && ei < EMIN;
        mul_result <= special || div_r ? '0 : acc[PW-2:MANT_W-1];
        redundant_mul <= !special && !div_r && acc[PW-1];
        div_result <= special || !div_r ? '0 : q;
      end
    end
  end
endmodule

// File: tb/tb_fpu_md_mantissa_core.sv
// tb_fpu_md_mantissa_core: scoreboard bench for the multiply/divide mantissa core.
module tb_fpu_md_mantissa_core;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, op_div = 1'b0;
  logic [31:0] op_a = '0, op_b = '0;
  logic ready, out_valid, sign, redundant_mul, div_mul, zero_flag, dbz_flag, exp_ovf, exp_unf;
  logic [7:0] exp;
  logic [23:0] mul_result, div_result;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {
    logic sign;
    logic [7:0] exp;
    logic [23:0] mul, dv;
    logic red, dm, zf, dbz, ovf, unf;
    int t0, lat;
  } exp_t;
  exp_t sb[$];
  fpu_md_mantissa_core dut (
    .clk(clk), .rst(rst), .start(start), .op_div(op_div), .op_a(op_a), .op_b(op_b),
    .ready(ready), .out_valid(out_valid), .sign(sign), .exp(exp),
    .mul_result(mul_result), .div_result(div_result), .redundant_mul(redundant_mul),
    .div_mul(div_mul), .zero_flag(zero_flag), .dbz_flag(dbz_flag),
    .exp_ovf(exp_ovf), .exp_unf(exp_unf)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic div);
    exp_t e;
    logic [7:0] ea, eb;
    logic [47:0] ma, mb, p, qt;
    int ei;
    ea = a[30:23];
    eb = b[30:23];
    ma = {24'd0, ea != 0, a[22:0]};
    mb = {24'd0, eb != 0, b[22:0]};
    e.sign = a[31] ^ b[31];
    e.dm = div;
    e.dbz = div && eb == 0;
    e.zf = !e.dbz && (ea == 0 || (!div && eb == 0));
    ei = div ? int'(ea) - int'(eb) + 127 : int'(ea) + int'(eb) - 127;
    e.ovf = 1'b0;
    e.unf = 1'b0;
    e.mul = '0;
    e.dv = '0;
    e.red = 1'b0;
    if (e.dbz) e.exp = 8'hFF;
    else if (e.zf) e.exp = 8'h00;
    else if (ei > 254) begin e.ovf = 1'b1; e.exp = 8'hFF; end
    else if (ei < 1) begin e.unf = 1'b1; e.exp = 8'h00; end
    else e.exp = ei[7:0];
    if (!e.dbz && !e.zf) begin
      if (div) begin
        qt = (ma << 23) / mb;
        e.dv = qt[23:0];
      end else begin
        p = ma * mb;
        e.red = p[47];
        e.mul = p[46:23];
      end
    end
    e.lat = e.dbz || e.zf ? 2 : 26;
    return e;
  endfunction
  task automatic wait_ready();
    for (int i = 0; i < 100 && !ready; i++) @(negedge clk);
    if (!ready) check("ready_timeout", 0, 1);
  endtask
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic div);
    exp_t e;
    wait_ready();
    e = model(a, b, div);
    e.t0 = cyc;
    sb.push_back(e);
    op_a = a;
    op_b = b;
    op_div = div;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  always @(negedge clk) if (out_valid) begin
    if (sb.size() == 0) check("spurious_valid", 1, 0);
    else begin
      exp_t e;
      e = sb.pop_front();
      check("latency", cyc - e.t0, e.lat);
      check("ready_after", ready, 1);
      check("sign", sign, e.sign);
      check("exp", exp, e.exp);
      check("mul_result", mul_result, e.mul);
      check("div_result", div_result, e.dv);
      check("redundant_mul", redundant_mul, e.red);
      check("div_mul", div_mul, e.dm);
      check("zero_flag", zero_flag, e.zf);
      check("dbz_flag", dbz_flag, e.dbz);
      check("exp_ovf", exp_ovf, e.ovf);
      check("exp_unf", exp_unf, e.unf);
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_valid", out_valid, 0);
    check("rst_exp", exp, 0);
    rst = 1'b0;
    @(negedge clk);
    do_op(32'h3FC00000, 32'h3FC00000, 1'b0);
    do_op(32'h40400000, 32'h40000000, 1'b1);
    do_op(32'h3F800000, 32'h3FC00000, 1'b1);
    do_op(32'h00000000, 32'hC0000000, 1'b0);
    do_op(32'h3F800000, 32'h00000000, 1'b1);
    do_op(32'h00000000, 32'h00000000, 1'b1);
    do_op(32'h00000000, 32'h40000000, 1'b1);
    do_op(32'h7F000000, 32'h7F000000, 1'b0);
    do_op(32'h00800000, 32'h00800000, 1'b0);
    do_op(32'hBFFFFFFF, 32'h3FFFFFFF, 1'b0);
    do_op(32'h3F800000, 32'hBFFFFFFF, 1'b1);
    do_op(32'h40A00000, 32'h3FC00000, 1'b0);
    repeat (5) @(negedge clk);
    op_a = 32'h12345678;
    op_b = 32'h0;
    op_div = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 8; i++)
      do_op({$urandom_range(1, 0), 8'($urandom_range(1, 254)), 23'($urandom)},
            {$urandom_range(1, 0), 8'($urandom_range(1, 254)), 23'($urandom)},
            1'($urandom_range(1, 0)));
    do_op(32'h7F000000, 32'h7F000000, 1'b0);
    do_op(32'h3FC00000, 32'h40000000, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready", ready, 1);
    check("midrst_valid", out_valid, 0);
    check("midrst_exp", exp, 0);
    check("midrst_ovf", exp_ovf, 0);
    check("midrst_divmul", div_mul, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    do_op(32'h40400000, 32'h3FC00000, 1'b1);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    check("drain", sb.size(), 0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
